// File: rtl/event_flag_scheduler.sv
// rtl/event_flag_scheduler.sv - set-dominant event flag bank with round-robin valid/ready scheduler
//
// Purpose: latches N event pulses into sticky flags and offers one pending,
// unmasked flag index at a time to a single consumer. Accepting an offer
// clears the granted flag unless it is set again on the same edge.
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst         synchronous reset, active-high
//   set_i       per-flag set pulse (dominates every clear)
//   clr_i       per-flag explicit clear
//   mask_i      1 = flag still latches but is not scheduled
//   out_valid   offer valid (registered)
//   out_idx     offered flag index (registered)
//   out_ready   consumer accepts the current offer
//   pend_o      raw flag register state
//   any_pend_o  |(pend_o & ~mask_i), combinational

module event_flag_scheduler #(
    parameter int N          = 8,
    parameter int GAP_CYCLES = 0,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     set_i,
    input  logic [N-1:0]     clr_i,
    input  logic [N-1:0]     mask_i,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N-1:0]     pend_o,
    output logic             any_pend_o
);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    state_t           state;
    logic [N-1:0]     pend;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       gap_cnt;

    logic [N-1:0]     eligible;
    logic [N-1:0]     acc_vec;
    logic             accept;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    int               j;

    assign pend_o     = pend;
    assign eligible   = pend & ~mask_i;
    assign any_pend_o = |eligible;
    assign accept     = out_valid & out_ready;

    // One-hot of the flag being granted this edge; ready without valid is ignored.
    always_comb begin
        acc_vec = '0;
        for (int i = 0; i < N; i++) begin
            acc_vec[i] = accept && (int'(out_idx) == i);
        end
    end

    // Circular priority search starting at ptr: ptr, ptr+1, ..., N-1, 0, ...
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!pick_found && eligible[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            state     <= SCAN;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
            gap_cnt   <= '0;
        end else begin
            // Set wins over both the explicit clear and the grant clear.
            pend <= set_i | (pend & ~clr_i & ~acc_vec);

            case (state)
                SCAN: begin
                    if (pick_found) begin
                        out_idx   <= pick_idx;
                        out_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    // Offer is committed: a later clear or mask does not withdraw it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (int'(out_idx) == N - 1) begin
                            ptr <= '0;
                        end else begin
                            ptr <= out_idx + 1'b1;
                        end
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                GAP: begin
                    // Leaving on count 1 spends exactly GAP_CYCLES cycles here.
                    if (gap_cnt <= 8'd1) begin
                        state <= SCAN;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= SCAN;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
